// File: rtl/keystream_quantizer.sv
// Purpose : starts the chaotic PRNG, drops its first DISCARD_N triplets, folds each later
//           float32 word into a key byte (x[7:0]^x[15:8]) and serves the bytes from a FIFO.
// Latency : start -> prng_tvalid 1 cycle; prng_valid into an empty FIFO -> k_valid 1 cycle.
// Backpr. : k_ready stalls only the FIFO head; the PRNG cannot be stalled, so a triplet that
//           does not fit is dropped whole and the sticky overflow flag is raised.
// Ports   : clk/reset (async, active-high); start+num_bytes request a keystream;
//           prng_tvalid/prng_valid/prng_x0..2 talk to the PRNG; k_data/k_valid/k_ready
//           carry key bytes; busy (WARMUP|RUN), done, overflow report status.
module keystream_quantizer #(
    parameter int PRECISION  = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int DISCARD_N  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [31:0]          num_bytes,
    output logic                 prng_tvalid,
    input  logic                 prng_valid,
    input  logic [PRECISION-1:0] prng_x0,
    input  logic [PRECISION-1:0] prng_x1,
    input  logic [PRECISION-1:0] prng_x2,
    output logic [7:0]           k_data,
    output logic                 k_valid,
    input  logic                 k_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [7:0] DISC_LAST = (DISCARD_N == 0) ? 8'd0 : 8'(DISCARD_N - 1);

    typedef enum logic [1:0] {IDLE, WARMUP, RUN, DONE} state_t;

    state_t          state;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic [CW-1:0]   free;
    logic [CW-1:0]   w_ext;
    logic [31:0]     remaining;
    logic [7:0]      disc_cnt;
    logic [1:0]      w;
    logic [2:0][7:0] key_bytes;
    logic            wr_en;
    logic            drop;
    logic            pop;
    logic            unused_hi;

    // Only the low 16 bits of each word feed the key byte.
    assign unused_hi = ^{prng_x0[PRECISION-1:16], prng_x1[PRECISION-1:16],
                         prng_x2[PRECISION-1:16]};

    assign key_bytes[0] = prng_x0[7:0] ^ prng_x0[15:8];
    assign key_bytes[1] = prng_x1[7:0] ^ prng_x1[15:8];
    assign key_bytes[2] = prng_x2[7:0] ^ prng_x2[15:8];

    assign k_valid = (count != '0);
    assign k_data  = k_valid ? mem[rd_ptr] : 8'h00;
    assign pop     = k_valid & k_ready;

    always_comb begin
        w          = (remaining >= 32'd3) ? 2'd3 : remaining[1:0];
        w_ext      = {{(CW-2){1'b0}}, w};
        // Free space is judged on the start-of-cycle count; a same-cycle pop is not credited.
        free       = CW'(FIFO_DEPTH) - count;
        wr_en      = (state == RUN) && prng_valid && (free >= w_ext);
        drop       = (state == RUN) && prng_valid && (free < w_ext);
        count_next = count + (wr_en ? w_ext : '0) - (pop ? CW'(1) : '0);
    end

    // Storage needs no reset: k_data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 3; i++) begin
                if (2'(i) < w) begin
                    mem[wr_ptr + AW'(i)] <= key_bytes[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            remaining   <= '0;
            disc_cnt    <= '0;
            prng_tvalid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            prng_tvalid <= 1'b0;
            count       <= count_next;
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(w);
            end
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        if (num_bytes != 32'd0) begin
                            remaining   <= num_bytes;
                            disc_cnt    <= '0;
                            prng_tvalid <= 1'b1;
                            overflow    <= 1'b0;
                            busy        <= 1'b1;
                            done        <= 1'b0;
                            state       <= (DISCARD_N == 0) ? RUN : WARMUP;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                WARMUP: begin
                    if (prng_valid) begin
                        if (disc_cnt == DISC_LAST) begin
                            state <= RUN;
                        end else begin
                            disc_cnt <= disc_cnt + 8'd1;
                        end
                    end
                end
                RUN: begin
                    if (wr_en) begin
                        remaining <= remaining - 32'(w);
                    end
                    if (drop) begin
                        overflow <= 1'b1;
                    end
                    // A write with w>0 always leaves bytes behind, so the current
                    // remaining is enough to detect the end of the stream.
                    if ((remaining == 32'd0) && (count_next == '0)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
